// File: rtl/bus_arb_pkg.sv
// Shared types for the two-master bus arbiter.
//   arb_state_e : arbiter FSM states
//   mst_idx_e   : master index (M0/M1)
//   bus_req_t   : request payload carried from a master to the slave side
//   ERR_DATA_DEF: read value returned to a master whose transfer was killed by the watchdog
package bus_arb_pkg;

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_e;

   typedef enum logic {M0 = 1'b0, M1 = 1'b1} mst_idx_e;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

   typedef struct packed {
      logic [31:0] addr;
      logic [2:0]  size;
      logic        write;
      logic [31:0] wdata;
   } bus_req_t;

   function automatic logic [1:0] idx_to_gnt(input mst_idx_e idx);
      return (idx == M1) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Transfer watchdog with a saturating event counter.
//   clk, rst    : clock, synchronous active-high reset
//   clr         : reload the down-counter (held while no transfer is in flight)
//   en          : count one stalled cycle
//   evt         : a timeout was taken; bump timeout_cnt
//   tc          : terminal count reached (the current cycle is the last one allowed)
//   timeout_cnt : saturating count of evt pulses since reset
module bus_watchdog #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             evt,
   output logic             tc,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int unsigned WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0]  wd_q, wd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Down-counter loaded with TIMEOUT-1 so it reaches zero on the TIMEOUT-th stalled cycle.
   always_comb begin
      wd_d = wd_q;
      if (clr) begin
         wd_d = WD_LOAD;
      end else if (en && (wd_q != '0)) begin
         wd_d = wd_q - WD_W'(1);
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (evt && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q  <= WD_LOAD;
         cnt_q <= '0;
      end else begin
         wd_q  <= wd_d;
         cnt_q <= cnt_d;
      end
   end

   assign tc          = (wd_q == '0);
   assign timeout_cnt = cnt_q;

endmodule

// File: rtl/bus_arbiter2.sv
// Round-robin arbiter sharing one valid/ready bus between two masters.
//   clk, rst                      : clock, synchronous active-high reset
//   m0_* / m1_*                   : master request payload, valid, read data and ready
//   s_addr/s_size/s_write/s_wdata : payload of the granted master, zero when idle
//   s_valid, s_rdata, s_ready     : slave-side handshake
//   gnt                           : one-hot grant (bit0 = m0, bit1 = m1)
//   timeout, timeout_cnt          : watchdog termination strobe and saturating count
//
// state | meaning
// IDLE  | no grant; arbitrate among pending requests
// BUSY  | grant held until slave ready, master drop or watchdog expiry
module bus_arbiter2 import bus_arb_pkg::*; #(
   parameter int unsigned TIMEOUT  = 64,
   parameter logic [31:0] ERR_DATA = ERR_DATA_DEF,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      m0_addr,
   input  logic [2:0]       m0_size,
   input  logic             m0_write,
   input  logic [31:0]      m0_wdata,
   input  logic             m0_valid,
   output logic [31:0]      m0_rdata,
   output logic             m0_ready,
   input  logic [31:0]      m1_addr,
   input  logic [2:0]       m1_size,
   input  logic             m1_write,
   input  logic [31:0]      m1_wdata,
   input  logic             m1_valid,
   output logic [31:0]      m1_rdata,
   output logic             m1_ready,
   output logic [31:0]      s_addr,
   output logic [2:0]       s_size,
   output logic             s_write,
   output logic [31:0]      s_wdata,
   output logic             s_valid,
   input  logic [31:0]      s_rdata,
   input  logic             s_ready,
   output logic [1:0]       gnt,
   output logic             timeout,
   output logic [CNT_W-1:0] timeout_cnt
);

   arb_state_e state_q, state_d;
   logic [1:0] gnt_q, gnt_d;
   mst_idx_e   last_q, last_d;

   bus_req_t   m0_req, m1_req, sel_req, s_req;
   mst_idx_e   sel, win;
   logic       sel_vld;
   logic       mst_ready;
   logic [31:0] mst_rdata;
   logic       wd_en, wd_tc;

   assign m0_req = '{addr: m0_addr, size: m0_size, write: m0_write, wdata: m0_wdata};
   assign m1_req = '{addr: m1_addr, size: m1_size, write: m1_write, wdata: m1_wdata};

   assign sel     = gnt_q[1] ? M1 : M0;
   assign sel_req = (sel == M1) ? m1_req : m0_req;
   assign sel_vld = (sel == M1) ? m1_valid : m0_valid;

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      win       = M0;
      s_req     = '0;
      s_valid   = 1'b0;
      mst_ready = 1'b0;
      mst_rdata = '0;
      timeout   = 1'b0;
      wd_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (m0_valid || m1_valid) begin
               if (m0_valid && m1_valid) begin
                  win = (last_q == M1) ? M0 : M1;
               end else begin
                  win = m1_valid ? M1 : M0;
               end
               gnt_d   = idx_to_gnt(win);
               state_d = BUSY;
            end
         end
         BUSY: begin
            s_req   = sel_req;
            s_valid = sel_vld;
            if (!sel_vld) begin
               // Master abandoned the request: release silently, round-robin order untouched.
               state_d = IDLE;
               gnt_d   = '0;
            end else if (s_ready) begin
               mst_ready = 1'b1;
               mst_rdata = s_rdata;
               state_d   = IDLE;
               gnt_d     = '0;
               last_d    = sel;
            end else if (wd_tc) begin
               mst_ready = 1'b1;
               mst_rdata = ERR_DATA;
               timeout   = 1'b1;
               s_valid   = 1'b0;
               state_d   = IDLE;
               gnt_d     = '0;
               last_d    = sel;
            end else begin
               wd_en = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         last_q  <= M1;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
      end
   end

   bus_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .clk         (clk),
      .rst         (rst),
      .clr         (state_q == IDLE),
      .en          (wd_en),
      .evt         (timeout),
      .tc          (wd_tc),
      .timeout_cnt (timeout_cnt)
   );

   assign s_addr  = s_req.addr;
   assign s_size  = s_req.size;
   assign s_write = s_req.write;
   assign s_wdata = s_req.wdata;

   assign gnt      = gnt_q;
   assign m0_ready = mst_ready && (sel == M0);
   assign m1_ready = mst_ready && (sel == M1);
   assign m0_rdata = (sel == M0) ? mst_rdata : '0;
   assign m1_rdata = (sel == M1) ? mst_rdata : '0;

endmodule

// File: tb/tb_bus_arbiter2.sv
module tb_bus_arbiter2;

   localparam int TIMEOUT = 64;
   localparam int CNT_W   = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
   localparam int N_RAND  = 40;

   logic        clk, rst;
   logic [1:0]  mv;
   logic [31:0] maddr [2];
   logic [2:0]  msize [2];
   logic [1:0]  mwr;
   logic [31:0] mwd [2];
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ready, m1_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [2:0]  s_size;
   logic        s_write, s_valid, s_ready;
   logic [1:0]  gnt;
   logic        timeout;
   logic [CNT_W-1:0] timeout_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   bus_arbiter2 #(.TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEADBEEF), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .m0_addr(maddr[0]), .m0_size(msize[0]), .m0_write(mwr[0]), .m0_wdata(mwd[0]),
      .m0_valid(mv[0]), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
      .m1_addr(maddr[1]), .m1_size(msize[1]), .m1_write(mwr[1]), .m1_wdata(mwd[1]),
      .m1_valid(mv[1]), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
      .s_addr(s_addr), .s_size(s_size), .s_write(s_write), .s_wdata(s_wdata),
      .s_valid(s_valid), .s_rdata(s_rdata), .s_ready(s_ready),
      .gnt(gnt), .timeout(timeout), .timeout_cnt(timeout_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      repeat (60000) @(posedge clk);
      $display("FAIL global_timeout: run exceeded 60000 cycles");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Transaction-level model: who owns the bus, how long it has waited, who was served last.
   logic mdl_on = 1'b0;
   int   own = -1;
   int   age = 0;
   int   last_won = 1;
   int   tcnt = 0;
   int   rdy_seen [2];
   int   nxt_own;
   bit   t_inc;
   logic [1:0]  e_gnt, e_rdy;
   logic        e_sv, e_to, e_wr;
   logic [31:0] e_addr, e_wd;
   logic [2:0]  e_size;
   logic [31:0] e_rd [2];

   always @(negedge clk) begin
      if (mdl_on) begin
         e_gnt = 2'b00; e_rdy = 2'b00; e_sv = 1'b0; e_to = 1'b0; e_wr = 1'b0;
         e_addr = '0; e_wd = '0; e_size = '0; e_rd[0] = '0; e_rd[1] = '0;
         nxt_own = own;
         t_inc = 1'b0;
         if (own < 0) begin
            if (mv != 2'b00) begin
               nxt_own = (mv == 2'b11) ? 1 - last_won : (mv[0] ? 0 : 1);
               age = 0;
            end
         end else begin
            e_gnt  = (own == 0) ? 2'b01 : 2'b10;
            e_addr = maddr[own]; e_size = msize[own]; e_wr = mwr[own]; e_wd = mwd[own];
            e_sv   = mv[own];
            if (!mv[own]) begin
               nxt_own = -1;
            end else if (s_ready) begin
               e_rdy[own] = 1'b1; e_rd[own] = s_rdata;
               nxt_own = -1; last_won = own;
            end else if (age == TIMEOUT - 1) begin
               e_rdy[own] = 1'b1; e_rd[own] = 32'hDEADBEEF; e_to = 1'b1; e_sv = 1'b0;
               nxt_own = -1; last_won = own; t_inc = 1'b1;
            end else begin
               age++;
            end
         end
         chk("cyc_gnt",      32'(gnt),         32'(e_gnt));
         chk("cyc_s_valid",  32'(s_valid),     32'(e_sv));
         chk("cyc_s_addr",   s_addr,           e_addr);
         chk("cyc_s_size",   32'(s_size),      32'(e_size));
         chk("cyc_s_write",  32'(s_write),     32'(e_wr));
         chk("cyc_s_wdata",  s_wdata,          e_wd);
         chk("cyc_m0_ready", 32'(m0_ready),    32'(e_rdy[0]));
         chk("cyc_m1_ready", 32'(m1_ready),    32'(e_rdy[1]));
         chk("cyc_m0_rdata", m0_rdata,         e_rd[0]);
         chk("cyc_m1_rdata", m1_rdata,         e_rd[1]);
         chk("cyc_timeout",  32'(timeout),     32'(e_to));
         chk("cyc_tcnt",     32'(timeout_cnt), 32'(tcnt));
         if (m0_ready) rdy_seen[0]++;
         if (m1_ready) rdy_seen[1]++;
         if (t_inc && tcnt < CNT_MAX) tcnt++;
         own = nxt_own;
         if (rst) begin
            own = -1; age = 0; last_won = 1; tcnt = 0;
         end
      end
   end

   // Bench RAM slave for 0x1000-0x1FFF with 0..3 wait states.
   logic [31:0] ram [1024];
   bit   slv_stop;
   int   slv_wait;
   int   issued [2];

   task automatic master_run(input int mi, input int n);
      logic [31:0] shadow [16];
      int idx, got;
      logic wr;
      logic [31:0] wd;
      for (int k = 0; k < 16; k++) shadow[k] = '0;
      for (int t = 0; t < n; t++) begin
         repeat ($urandom_range(0, 3)) step();
         idx = int'($urandom_range(0, 15));
         wr  = 1'($urandom_range(0, 1));
         wd  = $urandom;
         maddr[mi] = 32'h1000 + 32'(mi) * 32'h800 + 32'(idx) * 32'd4;
         msize[mi] = 3'd2; mwr[mi] = wr; mwd[mi] = wd; mv[mi] = 1'b1;
         got = 0;
         for (int c = 0; c < 200 && got == 0; c++) begin
            @(negedge clk);
            if ((mi == 0) ? m0_ready : m1_ready) begin
               got = 1;
               if (!wr) chk("rand_rdata", (mi == 0) ? m0_rdata : m1_rdata, shadow[idx]);
               else shadow[idx] = wd;
            end
            step();
         end
         chk("rand_served", 32'(got), 1);
         mv[mi] = 1'b0;
         issued[mi]++;
      end
   endtask

   logic [1:0] exp_seq [8];
   int got6, n_to;

   initial begin
      rst = 1'b1; mv = 2'b00; mwr = 2'b00;
      for (int i = 0; i < 2; i++) begin maddr[i] = '0; msize[i] = '0; mwd[i] = '0; end
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      s_ready = 1'b0; s_rdata = '0; slv_stop = 1'b0; slv_wait = 0;
      issued[0] = 0; issued[1] = 0; rdy_seen[0] = 0; rdy_seen[1] = 0;
      step();
      mdl_on = 1'b1; rst = 1'b0;
      @(negedge clk);
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_s_valid", 32'(s_valid), 0);
      chk("rst_tcnt", 32'(timeout_cnt), 0);

      // 1: lone m0 read, slave ready on the 2nd BUSY cycle
      step();
      mv[0] = 1'b1; maddr[0] = 32'h1000; msize[0] = 3'd2; mwr[0] = 1'b0;
      @(negedge clk); chk("t1_gnt_same_cycle", 32'(gnt), 0);
      step();
      @(negedge clk); chk("t1_gnt", 32'(gnt), 1); chk("t1_s_addr", s_addr, 32'h1000);
      chk("t1_m0_ready_early", 32'(m0_ready), 0);
      step(); s_ready = 1'b1; s_rdata = 32'hCAFE0001;
      @(negedge clk); chk("t1_m0_ready", 32'(m0_ready), 1); chk("t1_m0_rdata", m0_rdata, 32'hCAFE0001);
      chk("t1_m1_ready", 32'(m1_ready), 0);
      step(); mv[0] = 1'b0; s_ready = 1'b0; s_rdata = '0;
      @(negedge clk); chk("t1_gnt_released", 32'(gnt), 0);

      // 2: simultaneous requests after reset, zero-wait slave, continuous requests
      rst = 1'b1; step(); rst = 1'b0;
      mv = 2'b11; maddr[0] = 32'h1010; maddr[1] = 32'h1020; mwr = 2'b00;
      s_ready = 1'b1; s_rdata = 32'h0000_0022;
      exp_seq[0] = 2'b01; exp_seq[1] = 2'b00; exp_seq[2] = 2'b10; exp_seq[3] = 2'b00;
      exp_seq[4] = 2'b01; exp_seq[5] = 2'b00; exp_seq[6] = 2'b10; exp_seq[7] = 2'b00;
      @(negedge clk); chk("t2_gnt_req", 32'(gnt), 0);
      step();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t2_gnt_seq", 32'(gnt), 32'(exp_seq[i]));
         if (i == 0) chk("t2_m0_first", 32'(m0_ready), 1);
         if (i == 2) chk("t2_m1_second", 32'(m1_ready), 1);
         step();
      end
      mv = 2'b00; s_ready = 1'b0; s_rdata = '0;
      step();

      // 3: m1 write to stdout, slave never ready
      mv[1] = 1'b1; maddr[1] = 32'h3000; mwr[1] = 1'b1; mwd[1] = 32'h41; msize[1] = 3'd2;
      step();
      @(negedge clk); chk("t3_gnt", 32'(gnt), 2); chk("t3_s_addr", s_addr, 32'h3000);
      chk("t3_s_wdata", s_wdata, 32'h41); chk("t3_s_write", 32'(s_write), 1);
      for (int i = 1; i < TIMEOUT; i++) begin
         if (i > 1) @(negedge clk);
         if (i == TIMEOUT - 1) chk("t3_no_early_timeout", 32'(timeout), 0);
         step();
      end
      @(negedge clk);
      chk("t3_m1_ready", 32'(m1_ready), 1); chk("t3_m1_rdata", m1_rdata, 32'hDEADBEEF);
      chk("t3_timeout", 32'(timeout), 1); chk("t3_s_valid", 32'(s_valid), 0);
      step(); mv[1] = 1'b0; mwr[1] = 1'b0;
      @(negedge clk); chk("t3_tcnt", 32'(timeout_cnt), 1); chk("t3_gnt_released", 32'(gnt), 0);

      // 4: s_ready lands exactly on the last watchdog cycle
      mv[0] = 1'b1; maddr[0] = 32'h1100;
      step();
      for (int i = 1; i < TIMEOUT; i++) begin
         @(negedge clk);
         step();
      end
      s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
      @(negedge clk);
      chk("t4_m0_ready", 32'(m0_ready), 1); chk("t4_m0_rdata", m0_rdata, 32'h0BAD_F00D);
      chk("t4_timeout", 32'(timeout), 0);
      step(); mv[0] = 1'b0; s_ready = 1'b0; s_rdata = '0;
      @(negedge clk); chk("t4_tcnt_unchanged", 32'(timeout_cnt), 1);

      // 5: reset in the middle of a transfer
      mv[0] = 1'b1; maddr[0] = 32'h1004;
      step();
      @(negedge clk); chk("t5_gnt_busy", 32'(gnt), 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; mv = 2'b10; maddr[1] = 32'h3004; mwr[1] = 1'b0;
      @(negedge clk);
      chk("t5_gnt_after_rst", 32'(gnt), 0); chk("t5_s_valid", 32'(s_valid), 0);
      chk("t5_m0_ready", 32'(m0_ready), 0); chk("t5_tcnt", 32'(timeout_cnt), 0);
      step(); s_ready = 1'b1; s_rdata = 32'h0000_0041;
      @(negedge clk);
      chk("t5_m1_gnt", 32'(gnt), 2); chk("t5_m1_ready", 32'(m1_ready), 1);
      chk("t5_m1_rdata", m1_rdata, 32'h41);
      step(); mv = 2'b00; s_ready = 1'b0; s_rdata = '0;
      step();

      // 6: 300 back-to-back forced timeouts saturate the counter
      mv[0] = 1'b1; maddr[0] = 32'h1FFC;
      n_to = 0;
      for (int k = 0; k < 300; k++) begin
         got6 = 0;
         for (int c = 0; c < TIMEOUT + 10 && got6 == 0; c++) begin
            @(negedge clk);
            if (timeout) got6 = 1;
            step();
         end
         if (got6 == 0) chk("t6_timeout_seen", 32'(got6), 1);
         n_to += got6;
      end
      mv[0] = 1'b0;
      step();
      @(negedge clk);
      chk("t6_timeouts", 32'(n_to), 300);
      chk("t6_tcnt_saturated", 32'(timeout_cnt), 255);

      // random two-master traffic against the RAM slave
      step();
      rdy_seen[0] = 0; rdy_seen[1] = 0;
      fork
         begin
            fork
               master_run(0, N_RAND);
               master_run(1, N_RAND);
            join
            slv_stop = 1'b1;
         end
         begin
            while (!slv_stop) begin
               @(posedge clk);
               #2;
               s_ready = 1'b0; s_rdata = '0;
               if (!s_valid) begin
                  slv_wait = int'($urandom_range(0, 3));
               end else if (slv_wait == 0) begin
                  s_ready = 1'b1;
                  s_rdata = ram[s_addr[11:2]];
                  if (s_write) ram[s_addr[11:2]] = s_wdata;
               end else begin
                  slv_wait--;
               end
            end
            s_ready = 1'b0; s_rdata = '0;
         end
      join
      step();
      @(negedge clk);
      chk("rand_m0_once", 32'(rdy_seen[0]), N_RAND);
      chk("rand_m1_once", 32'(rdy_seen[1]), N_RAND);
      chk("rand_m0_issued", 32'(issued[0]), N_RAND);
      chk("rand_m1_issued", 32'(issued[1]), N_RAND);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
